muldiv_unit: RTL

Parametrised iterative multiply/divide unit with architectural HI/LO result registers, sitting beside the ALU in the multicycle datapath as the successor to the fixed 32-bit shift-add multiplier. It runs signed/unsigned multiply and divide over a configurable operand width using a start/busy/done handshake, so the control FSM can stall in a wait state until `done`. HI/LO persist between operations and can be written directly for `mthi`/`mtlo`.

---
 rtl/muldiv_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative signed/unsigned multiply/divide unit with
//               architectural HI/LO result registers. Uses a start/busy/done
//               handshake so the control FSM can stall until the result is
//               ready. One shift-add (multiply) or restoring (divide) step is
//               performed per cycle on a 2*WIDTH accumulator, followed by a
//               sign-fixup cycle.
//               Optional feature macro: MULDIV_DIV_EN
//                 defined   -> divide datapath present (div/divu supported)
//                 undefined -> divide omitted; div/divu raise op_err
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             op_err,
  output logic [CW-1:0]    counter
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // acc holds {partial product, multiplier} or {remainder, quotient}
  logic [2*WIDTH-1:0] acc_q,  acc_d;
  // operand held fixed during iteration: multiplicand or divisor magnitude
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q,  cnt_d;
  logic [WIDTH-1:0]   hi_q,   hi_d;
  logic [WIDTH-1:0]   lo_q,   lo_d;
  // product / quotient must be negated at the end
  logic               neg_q,  neg_d;
  logic               dbz_q,  dbz_d;
  logic               err_q,  err_d;

`ifdef MULDIV_DIV_EN
  logic               is_div_q, is_div_d;
  // remainder takes the sign of the dividend
  logic               rneg_q,   rneg_d;
`endif

  // Operand sign handling: signed ops (op[0]==0) work on magnitudes
  logic               op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               op_rejected;

  // Multiply step: conditional add of the multiplicand, then shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fin;

`ifdef MULDIV_DIV_EN
  // Divide step: shift the {remainder, quotient} pair left, trial subtract
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;
`endif

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & a[WIDTH-1];
  assign b_neg     = op_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

`ifdef MULDIV_DIV_EN
  assign op_rejected = 1'b0;
`else
  // Without divide hardware, div/divu requests are refused
  assign op_rejected = op[1];
`endif

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod_fin = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  // the difference is known to fit in WIDTH bits whenever it is used
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  assign quo_fin   = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
  assign rem_fin   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  // Next-state and datapath update; every register holds unless changed
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    dbz_d   = dbz_q;
    err_d   = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d = is_div_q;
    rneg_d   = rneg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && op_rejected) begin
          err_d = 1'b1;
        end else if (start) begin
          // start takes priority over any direct HI/LO write this cycle
          cnt_d   = CW'(WIDTH);
          dbz_d   = 1'b0;
          neg_d   = a_neg ^ b_neg;
          state_d = S_CALC;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          opnd_d  = a_mag;
`ifdef MULDIV_DIV_EN
          is_div_d = op[1];
          rneg_d   = a_neg;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
            if (b == '0) begin
              // zero divisor: result is defined, no iteration needed
              hi_d    = a;
              lo_d    = '1;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end
          end
`endif
        end else begin
          if (wr_hi) begin
            hi_d = wdata;
          end
          if (wr_lo) begin
            lo_d = wdata;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = mul_next;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          acc_d = div_next;
        end
`endif
        if (cnt_q == CW'(1)) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        hi_d = prod_fin[2*WIDTH-1:WIDTH];
        lo_d = prod_fin[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fin;
          lo_d = quo_fin;
        end
`endif
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      dbz_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      dbz_q   <= dbz_d;
      err_q   <= err_d;
    end
  end

`ifdef MULDIV_DIV_EN
  // Divide-only control bits
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      is_div_q <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      is_div_q <= is_div_d;
      rneg_q   <= rneg_d;
    end
  end
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign op_err      = err_q;
  assign counter     = cnt_q;

endmodule
`default_nettype wire
